// File: rtl/fifo_uart.sv
// Buffered 8N1 UART on the picorv32 native bus: TX/RX FIFOs, DIV/DATA/STATUS/CTRL
// registers, sticky W1C error flags and a registered level interrupt.
module fifo_uart #(
   parameter int unsigned FIFO_LOG2     = 4,
   parameter int unsigned DEFAULT_DIV   = 104,
   parameter bit          STALL_ON_FULL = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        ser_tx,
   input  logic        ser_rx,
   output logic        irq
);

   localparam int unsigned DEPTH = 1 << FIFO_LOG2;
   localparam int unsigned CW    = FIFO_LOG2 + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   // bus / registers
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rd_pop_q, rd_pop_d;
   logic [31:0] div_q, div_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [2:0]  err_q, err_d;       // {frame_err, tx_overflow, rx_overrun}
   logic        irq_q, irq_d;
   logic        bus_wr, stall, tx_push_req, tx_ovf_set, rx_ovr_set;
   logic [31:0] div_eff, status, rd_val;

   // FIFOs
   logic [7:0]           tx_mem_q [DEPTH];
   logic [7:0]           rx_mem_q [DEPTH];
   logic [FIFO_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [FIFO_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [CW-1:0]        tx_count_q, tx_count_d, rx_count_q, rx_count_d;
   logic                 tx_full, tx_empty, rx_full, rx_empty;
   logic                 tx_push, tx_pop, rx_push, rx_pop, rx_push_req;

   // TX engine
   uart_state_e tx_state_q, tx_state_d;
   logic [31:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        tx_line_q, tx_line_d;

   // RX engine
   uart_state_e rx_state_q, rx_state_d;
   logic [31:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   logic        frame_set;

   assign tx_full  = (tx_count_q == CW'(DEPTH));
   assign tx_empty = (tx_count_q == '0);
   assign rx_full  = (rx_count_q == CW'(DEPTH));
   assign rx_empty = (rx_count_q == '0);
   assign div_eff  = (div_q < 32'd2) ? 32'd2 : div_q;

   always_comb begin
      status                = '0;
      status[0]             = tx_full;
      status[1]             = tx_empty;
      status[2]             = ~rx_empty;
      status[3]             = rx_full;
      status[6:4]           = err_q;
      status[8 +: CW]       = rx_count_q;
      status[16 +: CW]      = tx_count_q;

      unique case (addr)
         2'd0:    rd_val = div_q;
         2'd1:    rd_val = rx_empty ? '1 : {24'h0, rx_mem_q[rx_rptr_q]};
         2'd2:    rd_val = status;
         default: rd_val = {30'h0, ctrl_q};
      endcase

      // Read data and the RX pop decision are captured the cycle before ready,
      // so the returned byte and the pop always refer to the same FIFO entry.
      bus_wr      = ready_q & sel & (wstrb != 4'h0);
      stall       = STALL_ON_FULL && (addr == 2'd1) && wstrb[0] && tx_full;
      ready_d     = sel & ~ready_q & ~stall;
      rdata_d     = (ready_d && wstrb == 4'h0) ? rd_val : '0;
      rd_pop_d    = ready_d && (wstrb == 4'h0) && (addr == 2'd1) && !rx_empty;
      rx_pop      = rd_pop_q;

      div_d = div_q;
      if (bus_wr && addr == 2'd0) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb[i]) div_d[8*i +: 8] = wdata[8*i +: 8];
         end
      end

      ctrl_d = ctrl_q;
      if (bus_wr && addr == 2'd3 && wstrb[0]) ctrl_d = wdata[1:0];

      tx_push_req = bus_wr && (addr == 2'd1) && wstrb[0];
      tx_ovf_set  = tx_push_req && tx_full && !tx_pop;
      rx_ovr_set  = rx_push_req && rx_full && !rx_pop;

      err_d = err_q;
      if (bus_wr && addr == 2'd2 && wstrb[0]) err_d = err_q & ~wdata[6:4];
      err_d = err_d | {frame_set, tx_ovf_set, rx_ovr_set};

      irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & (tx_state_q == S_IDLE));
   end

   always_comb begin
      tx_push    = tx_push_req && (!tx_full || tx_pop);
      rx_push    = rx_push_req && (!rx_full || rx_pop);
      tx_wptr_d  = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
      tx_rptr_d  = tx_pop  ? tx_rptr_q + 1'b1 : tx_rptr_q;
      rx_wptr_d  = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
      rx_rptr_d  = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;
      tx_count_d = tx_count_q;
      if (tx_push && !tx_pop) tx_count_d = tx_count_q + CW'(1);
      if (!tx_push && tx_pop) tx_count_d = tx_count_q - CW'(1);
      rx_count_d = rx_count_q;
      if (rx_push && !rx_pop) rx_count_d = rx_count_q + CW'(1);
      if (!rx_push && rx_pop) rx_count_d = rx_count_q - CW'(1);
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_div_d   = tx_div_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_pop     = 1'b0;

      unique case (tx_state_q)
         S_IDLE: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_state_d = S_START;
               tx_cnt_d   = '0;
               tx_div_d   = div_eff;
               tx_shift_d = tx_mem_q[tx_rptr_q];
            end
         end
         S_START, S_DATA, S_STOP: begin
            if (tx_cnt_q == tx_div_q - 32'd1) begin
               tx_cnt_d = '0;
               if (tx_state_q == S_START) begin
                  tx_state_d = S_DATA;
                  tx_bit_d   = '0;
               end else if (tx_state_q == S_DATA) begin
                  if (tx_bit_q == 3'd7) begin
                     tx_state_d = S_STOP;
                  end else begin
                     tx_bit_d   = tx_bit_q + 3'd1;
                     tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  end
               end else if (!tx_empty) begin
                  // back-to-back frame: straight from STOP into the next START
                  tx_pop     = 1'b1;
                  tx_state_d = S_START;
                  tx_div_d   = div_eff;
                  tx_shift_d = tx_mem_q[tx_rptr_q];
               end else begin
                  tx_state_d = S_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 32'd1;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase

      unique case (tx_state_d)
         S_START: tx_line_d = 1'b0;
         S_DATA:  tx_line_d = tx_shift_d[0];
         default: tx_line_d = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_div_d    = rx_div_q;
      rx_shift_d  = rx_shift_q;
      rx_bit_d    = rx_bit_q;
      rx_push_req = 1'b0;
      frame_set   = 1'b0;

      unique case (rx_state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = S_START;
               rx_cnt_d   = '0;
               rx_div_d   = div_eff;
            end
         end
         S_START: begin
            if (rx_cnt_q == (rx_div_q >> 1)) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 32'd1;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == rx_div_q - 32'd1) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q + 32'd1;
            end
         end
         S_STOP: begin
            if (rx_cnt_q == rx_div_q - 32'd1) begin
               rx_state_d  = S_IDLE;
               rx_push_req = rx_s2_q;
               frame_set   = ~rx_s2_q;
            end else begin
               rx_cnt_d = rx_cnt_q + 32'd1;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // FIFO storage carries no reset; occupancy counters guard every read.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wptr_q] <= wdata[7:0];
      if (rx_push) rx_mem_q[rx_wptr_q] <= rx_shift_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         rd_pop_q   <= 1'b0;
         div_q      <= 32'(DEFAULT_DIV);
         ctrl_q     <= '0;
         err_q      <= '0;
         irq_q      <= 1'b0;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         tx_count_q <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         rx_count_q <= '0;
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= 32'd2;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         tx_line_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= 32'd2;
         rx_shift_q <= '0;
         rx_bit_q   <= '0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         rd_pop_q   <= rd_pop_d;
         div_q      <= div_d;
         ctrl_q     <= ctrl_d;
         err_q      <= err_d;
         irq_q      <= irq_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         tx_count_q <= tx_count_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         rx_count_q <= rx_count_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         tx_line_q  <= tx_line_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_shift_q <= rx_shift_d;
         rx_bit_q   <= rx_bit_d;
         rx_s1_q    <= ser_rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
      end
   end

   assign ready  = ready_q;
   assign rdata  = rdata_q;
   assign ser_tx = tx_line_q;
   assign irq    = irq_q;

endmodule
